// File: rtl/mbr_handshake_if.sv
// Memory-side bus of the memory buffer register.
//
// Handshake: the master raises mem_req together with mem_we, mem_addr and
// mem_wdata, and holds all four stable until the first rising edge at which
// the slave drives mem_ack=1 (mem_rdata is sampled at that same edge for a
// read) or until the master gives up on a timeout. mem_ack is only
// meaningful while mem_req=1.
//
// Signals
//   mem_req    master -> slave  transaction request
//   mem_we     master -> slave  1 = write, 0 = read (valid while mem_req=1)
//   mem_addr   master -> slave  transaction address
//   mem_wdata  master -> slave  write data
//   mem_ack    slave -> master  completes the current transaction
//   mem_rdata  slave -> master  read data, valid with mem_ack
interface mbr_handshake_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mbr_handshake.sv
// Memory buffer register: holds the CPU data word between the accumulator
// and RAM. It loads from the accumulator or runs one read/write bus
// transaction at a time over a req/ack handshake with a wait-state timeout.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   ld_acc       pulse: mbr_data <= acc_data (only while idle)
//   wr_start     pulse: write mbr_data to memory at addr_in
//   rd_start     pulse: read memory at addr_in into mbr_data
//   err_clr      clears the sticky err flag
//   addr_in      transaction address, sampled when a command is accepted
//   acc_data     accumulator value
//   mem          memory bus (master side)
//   mbr_data     buffer register contents
//   busy         high while a transaction is outstanding
//   done         one-cycle pulse after an acked transaction
//   err          sticky timeout flag
//   state_dbg    current FSM state (0 IDLE, 1 RD_WAIT, 2 WR_WAIT)
module mbr_handshake #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_acc,
  input  logic              wr_start,
  input  logic              rd_start,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] acc_data,
  mbr_handshake_if.master   mem,
  output logic [DATA_W-1:0] mbr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // TIMEOUT=0 still needs a legal 1-bit counter even though it never counts.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mbr_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mbr_q   <= mbr_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mbr_d   = mbr_q;
    addr_d  = addr_q;
    req_d   = req_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = err_q;

    // err_clr is applied first so a timeout on the same edge overrides it.
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Priority ld_acc > wr_start > rd_start; losers are dropped.
        if (ld_acc) begin
          mbr_d = acc_data;
        end else if (wr_start || rd_start) begin
          addr_d  = addr_in;
          req_d   = 1'b1;
          we_d    = wr_start;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = wr_start ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (state_q == RD_WAIT) mbr_d = mem.mem_rdata;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = mbr_q;
  assign mbr_data      = mbr_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mbr_handshake.sv
// Bench for mbr_handshake. Two instances: u_dut with TIMEOUT=15 and
// u_dut_nt with TIMEOUT=0. Expected values come from a transaction-level
// model: a transaction acked k cycles after acceptance finishes after
// min(k, TIMEOUT) edges; it times out when k exceeds TIMEOUT.
module tb_mbr_handshake;
  localparam int TMO  = 15;
  localparam int MAXW = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with timeout ----------------
  logic        ld_acc, wr_start, rd_start, err_clr;
  logic [7:0]  addr_in;
  logic [15:0] acc_data;
  logic [15:0] mbr_data;
  logic        busy, done, err;
  logic [1:0]  state_dbg;

  mbr_handshake_if #(.DATA_W(16), .ADDR_W(8)) bus0 ();

  mbr_handshake #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .ld_acc(ld_acc), .wr_start(wr_start),
    .rd_start(rd_start), .err_clr(err_clr), .addr_in(addr_in),
    .acc_data(acc_data), .mem(bus0.master), .mbr_data(mbr_data),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- DUT without timeout ----------------
  logic        ld_acc_b, wr_start_b, rd_start_b, err_clr_b;
  logic [7:0]  addr_in_b;
  logic [15:0] acc_data_b;
  logic [15:0] mbr_data_b;
  logic        busy_b, done_b, err_b;
  logic [1:0]  state_dbg_b;

  mbr_handshake_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();

  mbr_handshake #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(0)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .ld_acc(ld_acc_b), .wr_start(wr_start_b),
    .rd_start(rd_start_b), .err_clr(err_clr_b), .addr_in(addr_in_b),
    .acc_data(acc_data_b), .mem(bus1.master), .mbr_data(mbr_data_b),
    .busy(busy_b), .done(done_b), .err(err_b), .state_dbg(state_dbg_b)
  );

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_mbr;
  logic        m_err;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ld_acc = 0; wr_start = 0; rd_start = 0; err_clr = 0;
    addr_in = '0; acc_data = '0;
    bus0.mem_ack = 0; bus0.mem_rdata = '0;
    ld_acc_b = 0; wr_start_b = 0; rd_start_b = 0; err_clr_b = 0;
    addr_in_b = '0; acc_data_b = '0;
    bus1.mem_ack = 0; bus1.mem_rdata = '0;
  endtask

  // Issue one bus transaction on u_dut; memory acks k edges after accept.
  task automatic do_txn(input bit is_rd, input logic [7:0] addr, input int k,
                        input logic [15:0] rdata, input bit hold_clr);
    int edges;
    int exp_edges;
    bit tmo;
    tmo = (k > TMO);
    exp_edges = tmo ? TMO : k;
    if (is_rd) rd_start = 1; else wr_start = 1;
    addr_in = addr;
    step();
    rd_start = 0; wr_start = 0; addr_in = 8'($urandom);
    m_err = 1'b0;
    n_checks++;
    if ({bus0.mem_req, bus0.mem_we, bus0.mem_addr, busy, err} !== {1'b1, ~is_rd, addr, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL txn_accept: {req,we,addr,busy,err}=%h expected %h",
               {bus0.mem_req, bus0.mem_we, bus0.mem_addr, busy, err}, {1'b1, ~is_rd, addr, 1'b1, 1'b0});
    end
    n_checks++;
    if (bus0.mem_wdata !== m_mbr) begin
      n_fail++;
      $display("FAIL txn_wdata: got %h expected %h", bus0.mem_wdata, m_mbr);
    end
    err_clr = hold_clr;
    edges = 0;
    while (busy === 1'b1 && edges < MAXW) begin
      edges++;
      bus0.mem_ack   = (edges == k);
      bus0.mem_rdata = (edges == k) ? rdata : 16'($urandom);
      step();
      bus0.mem_ack = 0;
      if (busy === 1'b1) begin
        n_checks++;
        if ({bus0.mem_req, done} !== 2'b10) begin
          n_fail++;
          $display("FAIL txn_wait: {req,done}=%b expected 10 at wait %0d", {bus0.mem_req, done}, edges);
        end
      end
    end
    err_clr = 0;
    exp_q.push_back((is_rd && !tmo) ? rdata : m_mbr);
    if (tmo) m_err = 1'b1;
    m_mbr = exp_q.pop_front();
    n_checks++;
    if (edges != exp_edges) begin
      n_fail++;
      $display("FAIL txn_latency: got %0d edges expected %0d", edges, exp_edges);
    end
    n_checks++;
    if ({done, err, bus0.mem_req} !== {~tmo, m_err, 1'b0}) begin
      n_fail++;
      $display("FAIL txn_end: {done,err,req}=%b expected %b", {done, err, bus0.mem_req}, {~tmo, m_err, 1'b0});
    end
    n_checks++;
    if (mbr_data !== m_mbr || bus0.mem_wdata !== m_mbr) begin
      n_fail++;
      $display("FAIL txn_data: mbr=%h wdata=%h expected %h", mbr_data, bus0.mem_wdata, m_mbr);
    end
    step();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL txn_pulse: {done,busy}=%b expected 00", {done, busy});
    end
  endtask

  task automatic load_acc(input logic [15:0] v);
    ld_acc = 1; acc_data = v;
    step();
    ld_acc = 0; acc_data = 16'($urandom);
    m_mbr = v;
    n_checks++;
    if ({mbr_data, busy, done} !== {v, 2'b00}) begin
      n_fail++;
      $display("FAIL ld_acc: {mbr,busy,done}=%h expected %h", {mbr_data, busy, done}, {v, 2'b00});
    end
  endtask

  // One idle cycle with optional err_clr and a stray mem_ack.
  task automatic idle_cycle(input bit clr, input bit stray_ack);
    err_clr = clr;
    bus0.mem_ack = stray_ack;
    bus0.mem_rdata = 16'($urandom);
    step();
    err_clr = 0; bus0.mem_ack = 0;
    if (clr) m_err = 1'b0;
    n_checks++;
    if ({mbr_data, err, busy, done, bus0.mem_req} !== {m_mbr, m_err, 3'b000}) begin
      n_fail++;
      $display("FAIL idle_cycle: {mbr,err,busy,done,req}=%h expected %h",
               {mbr_data, err, busy, done, bus0.mem_req}, {m_mbr, m_err, 3'b000});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] v;
    #1;
    n_checks++;
    if ({mbr_data, bus0.mem_req, bus0.mem_we, bus0.mem_addr, done, err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs=%h expected 0",
               {mbr_data, bus0.mem_req, bus0.mem_we, bus0.mem_addr, done, err, busy});
    end
    @(negedge clk);
    rst_n = 1;
    m_mbr = '0; m_err = 1'b0;
    v = 16'($urandom) | 16'h0001;
    load_acc(v);
    rd_start = 1; addr_in = 8'h5A;
    step();
    rd_start = 0;
    n_checks++;
    if ({bus0.mem_req, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_pre: {req,busy}=%b expected 11", {bus0.mem_req, busy});
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({mbr_data, bus0.mem_req, bus0.mem_we, bus0.mem_addr, done, err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: outputs=%h expected 0",
               {mbr_data, bus0.mem_req, bus0.mem_we, bus0.mem_addr, done, err, busy});
    end
    @(negedge clk);
    rst_n = 1;
    m_mbr = '0; m_err = 1'b0;
    step();
    n_checks++;
    if ({busy, bus0.mem_req, mbr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: {busy,req,mbr}=%h expected 0", {busy, bus0.mem_req, mbr_data});
    end
  endtask

  task automatic test_write();
    load_acc(16'hA5A5);
    do_txn(1'b0, 8'h10, 3, 16'($urandom), 1'b0);
  endtask

  task automatic test_read_fast();
    do_txn(1'b1, 8'h22, 1, 16'h1234, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 8'h33, 100, 16'($urandom), 1'b0);
    idle_cycle(1'b1, 1'b0);
    // timeout and err_clr on the same edge: timeout wins
    do_txn(1'b1, 8'h44, 100, 16'($urandom), 1'b1);
    idle_cycle(1'b1, 1'b0);
  endtask

  task automatic test_priority();
    logic [15:0] v, rd;
    v = 16'($urandom);
    ld_acc = 1; wr_start = 1; rd_start = 1; acc_data = v; addr_in = 8'h77;
    step();
    ld_acc = 0; wr_start = 0; rd_start = 0;
    m_mbr = v;
    n_checks++;
    if ({mbr_data, busy, bus0.mem_req, done} !== {v, 3'b000}) begin
      n_fail++;
      $display("FAIL priority: {mbr,busy,req,done}=%h expected %h",
               {mbr_data, busy, bus0.mem_req, done}, {v, 3'b000});
    end
    rd_start = 1; addr_in = 8'h61;
    step();
    rd_start = 1; wr_start = 1; ld_acc = 1; addr_in = 8'h62; acc_data = ~v;
    step();
    rd_start = 0; wr_start = 0; ld_acc = 0;
    n_checks++;
    if ({bus0.mem_req, bus0.mem_we, bus0.mem_addr, mbr_data} !== {2'b10, 8'h61, m_mbr}) begin
      n_fail++;
      $display("FAIL busy_ignore: {req,we,addr,mbr}=%h expected %h",
               {bus0.mem_req, bus0.mem_we, bus0.mem_addr, mbr_data}, {2'b10, 8'h61, m_mbr});
    end
    rd = 16'($urandom);
    bus0.mem_ack = 1; bus0.mem_rdata = rd;
    step();
    bus0.mem_ack = 0;
    m_mbr = rd;
    n_checks++;
    if ({mbr_data, done, busy} !== {rd, 2'b10}) begin
      n_fail++;
      $display("FAIL busy_ack: {mbr,done,busy}=%h expected %h", {mbr_data, done, busy}, {rd, 2'b10});
    end
    idle_cycle(1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: load_acc(16'($urandom));
        1: do_txn(1'b0, 8'($urandom), $urandom_range(1, 20), 16'($urandom), 1'($urandom));
        2: do_txn(1'b1, 8'($urandom), $urandom_range(1, 20), 16'($urandom), 1'($urandom));
        default: idle_cycle(1'($urandom), 1'($urandom));
      endcase
    end
  endtask

  task automatic test_no_timeout();
    int edges;
    logic [15:0] rd;
    rd = 16'($urandom);
    rd_start_b = 1; addr_in_b = 8'h99;
    step();
    rd_start_b = 0;
    edges = 0;
    while (busy_b === 1'b1 && edges < MAXW) begin
      edges++;
      bus1.mem_ack = (edges == 40);
      bus1.mem_rdata = (edges == 40) ? rd : 16'($urandom);
      step();
      bus1.mem_ack = 0;
      if (busy_b === 1'b1) begin
        n_checks++;
        if ({bus1.mem_req, err_b, bus1.mem_addr} !== {2'b10, 8'h99}) begin
          n_fail++;
          $display("FAIL nt_wait: {req,err,addr}=%h expected %h at wait %0d",
                   {bus1.mem_req, err_b, bus1.mem_addr}, {2'b10, 8'h99}, edges);
        end
      end
    end
    n_checks++;
    if (edges != 40) begin
      n_fail++;
      $display("FAIL nt_latency: got %0d edges expected 40", edges);
    end
    n_checks++;
    if ({mbr_data_b, done_b, err_b, bus1.mem_req} !== {rd, 3'b100}) begin
      n_fail++;
      $display("FAIL nt_end: {mbr,done,err,req}=%h expected %h",
               {mbr_data_b, done_b, err_b, bus1.mem_req}, {rd, 3'b100});
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read_fast();
    test_timeout();
    test_priority();
    test_random();
    test_no_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
